// File: rtl/bram_pkg.sv
// bram_pkg
// Shared types and constants for the block-RAM port-A stream writer.
//   wr_state_t   : write sequencer state (IDLE -> WRITE -> DONE -> IDLE)
//   DEF_*        : default parameter values used by the writer and its bench
//   WE_ALL       : all-ones byte enable for the default data width
package bram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_DEPTH     = 1024;
    localparam int DEF_ADDR_STEP = 1;
    localparam int LEN_W         = 16;

    localparam logic [DEF_DATA_W/8-1:0] WE_ALL = '1;

endpackage

// File: rtl/bram_stream_writer_if.sv
// bram_stream_writer_if
// Groups the incoming word stream and the RAM port-A write bus.
//   s_data/s_valid/s_last : stream from the producer
//   s_ready               : stream back-pressure from the writer
//   addra/dina/ena/wea    : RAM port-A write bus driven by the writer
// Handshake: a word transfers on a rising clka edge where s_valid and s_ready
// are both high; s_valid/s_data/s_last must stay stable until that edge, and
// s_ready never depends combinationally on s_valid.
// Modports: master = the writer (consumes stream, drives RAM port A);
//           slave  = the environment (produces stream, observes RAM port A).
interface bram_stream_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [ADDR_W-1:0]   addra;
    logic [DATA_W-1:0]   dina;
    logic                ena;
    logic [DATA_W/8-1:0] wea;

    modport master (
        input  s_data, s_valid, s_last,
        output s_ready, addra, dina, ena, wea
    );

    modport slave (
        output s_data, s_valid, s_last,
        input  s_ready, addra, dina, ena, wea
    );
endinterface

// File: rtl/bram_addr_gen.sv
// bram_addr_gen
// Loadable word pointer that walks RAM locations modulo DEPTH and scales the
// pointer into a RAM address.
//   clka, rsta : clock, synchronous active-high reset (pointer -> 0)
//   load       : load pointer from load_val (truncated to log2(DEPTH) bits)
//   load_val   : starting word index
//   inc        : advance pointer by one word, DEPTH-1 wraps to 0
//   addr       : pointer * ADDR_STEP, zero-extended to ADDR_W (combinational)
module bram_addr_gen #(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_STEP = 1
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Upper base-address bits are deliberately discarded.
    if (ADDR_W > PTR_W) begin : g_trunc
        logic unused_load_hi;
        assign unused_load_hi = ^load_val[ADDR_W-1:PTR_W];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val[PTR_W-1:0];
        end else if (inc) begin
            // DEPTH is a power of two, so natural overflow gives the modulo wrap.
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign addr = ADDR_W'(ptr_q) * ADDR_W'(ADDR_STEP);

endmodule

// File: rtl/bram_stream_writer.sv
// bram_stream_writer
// Port-A write sequencer for a dual-port block RAM. A start command latches a
// base word index and a word count; stream words are then written to
// consecutive RAM locations, one per accepted handshake.
//   clka, rsta       : clock, synchronous active-high reset
//   start            : one-cycle command, honoured only in IDLE
//   base_addr        : first word index, sampled with start
//   length           : words to write, sampled with start
//   bus (master)     : stream in (s_*), RAM port A out (addra/dina/ena/wea)
//   busy             : high while a command is in WRITE or DONE
//   done             : one-cycle pulse, same cycle as the final write enable
//   words_written    : words committed by the current or last command
//   err_short        : sticky, s_last arrived before length words
//   state_dbg        : current FSM state
module bram_stream_writer
    import bram_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    bram_stream_writer_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_written,
    output logic              err_short,
    output wr_state_t         state_dbg
);
    localparam int WE_W = DATA_W / 8;

    wr_state_t         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  ww_q, ww_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              ena_q, ena_d;
    logic [WE_W-1:0]   wea_q, wea_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              ptr_load;
    logic              ptr_inc;
    logic [ADDR_W-1:0] ptr_addr;
    logic              s_ready;
    logic              hs;
    logic              final_word;

    bram_addr_gen #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .ADDR_STEP (ADDR_STEP)
    ) u_addr_gen (
        .clka     (clka),
        .rsta     (rsta),
        .load     (ptr_load),
        .load_val (base_addr),
        .inc      (ptr_inc),
        .addr     (ptr_addr)
    );

    // Ready depends on the state register alone, never on s_valid.
    assign s_ready    = (state_q == WRITE);
    assign hs         = bus.s_valid & s_ready;
    // len_q is non-zero whenever WRITE is entered, so len_q-1 cannot underflow here.
    assign final_word = (ww_q == len_q - LEN_W'(1));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ww_d     = ww_q;
        err_d    = err_q;
        addra_d  = addra_q;
        dina_d   = dina_q;
        ena_d    = 1'b0;
        wea_d    = '0;
        ptr_load = 1'b0;
        ptr_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = length;
                    ww_d     = '0;
                    err_d    = 1'b0;
                    ptr_load = 1'b1;
                    state_d  = (length == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (hs) begin
                    dina_d  = bus.s_data;
                    addra_d = ptr_addr;
                    ena_d   = 1'b1;
                    wea_d   = '1;
                    ptr_inc = 1'b1;
                    ww_d    = ww_q + LEN_W'(1);
                    if (final_word || bus.s_last) begin
                        state_d = DONE;
                        // An s_last that lands exactly on the final word is not short.
                        if (bus.s_last && !final_word) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // done/busy are registered copies of the next state, so they line up
        // with the state register and with the final write's ena.
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= IDLE;
            len_q   <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            ena_q   <= 1'b0;
            wea_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ww_q    <= ww_d;
            err_q   <= err_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            ena_q   <= ena_d;
            wea_q   <= wea_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.addra      = addra_q;
    assign bus.dina       = dina_q;
    assign bus.ena        = ena_q;
    assign bus.wea        = wea_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign words_written  = ww_q;
    assign err_short      = err_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_bram_stream_writer.sv
// tb_bram_stream_writer
// Directed bench for bram_stream_writer. Two writers share one stimulus: one
// with word addressing (ADDR_STEP 1) and one with byte addressing (ADDR_STEP 4).
// Accepted words are pushed to an expected queue and popped when port A fires.
module tb_bram_stream_writer;
    import bram_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DEP = 1024;
    localparam int EW  = 10 + DW;

    // ---------------- clock / reset ----------------
    logic clka = 1'b0;
    logic rsta = 1'b1;
    always #5 clka = ~clka;

    // ---------------- stimulus signals ----------------
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   length = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;

    bram_stream_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    bram_stream_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();
    assign bus1.s_data  = s_data;
    assign bus1.s_valid = s_valid;
    assign bus1.s_last  = s_last;
    assign bus4.s_data  = s_data;
    assign bus4.s_valid = s_valid;
    assign bus4.s_last  = s_last;

    logic        busy1, done1, err1, busy4, done4, err4;
    logic [15:0] ww1, ww4;
    wr_state_t   st1, st4;

    bram_stream_writer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ADDR_STEP(1)) u_dut (
        .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .length(length),
        .bus(bus1), .busy(busy1), .done(done1), .words_written(ww1),
        .err_short(err1), .state_dbg(st1)
    );

    bram_stream_writer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ADDR_STEP(4)) u_dut4 (
        .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .length(length),
        .bus(bus4), .busy(busy4), .done(done4), .words_written(ww4),
        .err_short(err4), .state_dbg(st4)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] exp_mem[DEP];
    logic [DW-1:0] ram[DEP];
    logic [9:0]    exp_ptr = '0;
    logic          drv_hs = 1'b0;
    logic          exp_ena_q = 1'b0;
    logic          mon_en = 1'b0;
    int            ena_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM model standing in for the port-A side of the block RAM.
    always @(posedge clka) begin
        if (bus1.ena && bus1.wea == 4'hF) ram[bus1.addra[9:0]] <= bus1.dina;
    end

    // A handshake driven before an edge must show up as ena after that edge;
    // reset at that edge suppresses it.
    always @(posedge clka) exp_ena_q <= rsta ? 1'b0 : drv_hs;

    logic [EW-1:0] mon_e;
    always @(negedge clka) begin
        if (mon_en) begin
            chk("ena", {63'd0, bus1.ena}, {63'd0, exp_ena_q});
            chk("ena4", {63'd0, bus4.ena}, {63'd0, exp_ena_q});
            if (bus1.ena) begin
                ena_cnt++;
                chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("addra", {32'd0, bus1.addra}, {54'd0, mon_e[EW-1:DW]});
                    chk("addra4", {32'd0, bus4.addra}, {52'd0, mon_e[EW-1:DW], 2'b00});
                    chk("dina", {32'd0, bus1.dina}, {32'd0, mon_e[DW-1:0]});
                    chk("dina4", {32'd0, bus4.dina}, {32'd0, mon_e[DW-1:0]});
                    chk("wea", {60'd0, bus1.wea}, 64'hF);
                    chk("wea4", {60'd0, bus4.wea}, 64'hF);
                end
            end
        end
    end

    // ---------------- driver tasks (entered/left just after a negedge) ----------------
    task automatic cmd(input int base, input int len);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = 16'(len);
        exp_ptr   = 10'(base);
        chk("idle_not_ready", {63'd0, bus1.s_ready}, 64'd0);
        @(negedge clka);
        start = 1'b0;
    endtask

    // Drives stream words until stop_after words are accepted. The writer is
    // expected to be in WRITE for every driven cycle. last_idx marks s_last on
    // that accepted-word index; start_at injects a stray start on that cycle.
    task automatic drive(input int toggle, input int last_idx, input int stop_after,
                         input int start_at);
        int acc = 0;
        int cyc = 0;
        bit phase = 1'b1;
        while (acc < stop_after && cyc < 400) begin
            s_valid = toggle ? phase : 1'b1;
            phase   = ~phase;
            s_data  = $urandom;
            s_last  = s_valid && (acc == last_idx);
            start   = (cyc == start_at);
            if (cyc == start_at) begin
                length    = 16'd2;
                base_addr = '0;
            end
            drv_hs = s_valid;
            chk("s_ready", {63'd0, bus1.s_ready}, 64'd1);
            if (s_valid) begin
                exp_q.push_back({exp_ptr, s_data});
                exp_mem[exp_ptr] = s_data;
                exp_ptr = exp_ptr + 10'd1;
                acc++;
            end
            @(negedge clka);
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        drv_hs  = 1'b0;
        chk("drv_timeout", {63'd0, cyc < 400}, 64'd1);
    endtask

    task automatic expect_done(input string tag, input int ww, input bit err);
        chk({tag, "_done"}, {63'd0, done1}, 64'd1);
        chk({tag, "_done4"}, {63'd0, done4}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy1}, 64'd1);
        chk({tag, "_ww"}, {48'd0, ww1}, 64'(ww));
        chk({tag, "_err"}, {63'd0, err1}, {63'd0, err});
        @(negedge clka);
        chk({tag, "_done_pulse"}, {63'd0, done1}, 64'd0);
        chk({tag, "_idle_busy"}, {63'd0, busy1}, 64'd0);
        chk({tag, "_idle_state"}, 64'(st1), 64'(IDLE));
        chk({tag, "_ww_hold"}, {48'd0, ww1}, 64'(ww));
    endtask

    // ---------------- directed sequence ----------------
    int n0;
    initial begin
        repeat (3) @(negedge clka);
        rsta   = 1'b0;
        mon_en = 1'b1;
        chk("rst_state", 64'(st1), 64'(IDLE));
        chk("rst_ready", {63'd0, bus1.s_ready}, 64'd0);
        chk("rst_done", {63'd0, done1}, 64'd0);
        chk("rst_busy", {63'd0, busy1}, 64'd0);
        chk("rst_err", {63'd0, err1}, 64'd0);
        chk("rst_ww", {48'd0, ww1}, 64'd0);
        chk("rst_addra", {32'd0, bus1.addra}, 64'd0);
        chk("rst_dina", {32'd0, bus1.dina}, 64'd0);
        chk("rst_wea", {60'd0, bus1.wea}, 64'd0);

        // 100 words from base 0, valid held.
        n0 = ena_cnt;
        cmd(0, 100);
        drive(0, -1, 100, -1);
        expect_done("len100", 100, 1'b0);
        chk("len100_ena_cnt", 64'(ena_cnt - n0), 64'd100);
        for (int i = 0; i < 100; i++) chk("readback", {32'd0, ram[i]}, {32'd0, exp_mem[i]});

        // Valid toggling every other cycle.
        n0 = ena_cnt;
        cmd(200, 8);
        drive(1, -1, 8, -1);
        expect_done("toggle", 8, 1'b0);
        chk("toggle_ena_cnt", 64'(ena_cnt - n0), 64'd8);

        // Pointer wrap at the top of the RAM.
        cmd(1022, 4);
        drive(0, -1, 4, -1);
        expect_done("wrap", 4, 1'b0);
        chk("wrap_ram_1023", {32'd0, ram[1023]}, {32'd0, exp_mem[1023]});
        chk("wrap_ram_1", {32'd0, ram[1]}, {32'd0, exp_mem[1]});

        // Early s_last on the third word.
        cmd(400, 10);
        drive(0, 2, 3, -1);
        expect_done("short", 3, 1'b1);
        chk("short_err_sticky", {63'd0, err1}, 64'd1);
        // Next start clears the error; s_last on the final word is not short.
        cmd(410, 2);
        chk("err_cleared", {63'd0, err1}, 64'd0);
        drive(0, 1, 2, -1);
        expect_done("last_exact", 2, 1'b0);

        // Zero length: done one cycle after start, no write.
        n0 = ena_cnt;
        cmd(5, 0);
        chk("len0_done", {63'd0, done1}, 64'd1);
        chk("len0_ready", {63'd0, bus1.s_ready}, 64'd0);
        @(negedge clka);
        chk("len0_done_pulse", {63'd0, done1}, 64'd0);
        chk("len0_no_ena", 64'(ena_cnt - n0), 64'd0);

        // Stray start during WRITE is ignored.
        cmd(300, 6);
        drive(0, -1, 6, 2);
        expect_done("stray_start", 6, 1'b0);

        // Reset mid-command after 5 of 20 words.
        cmd(50, 20);
        drive(0, -1, 5, -1);
        rsta    = 1'b1;
        s_valid = 1'b1;
        s_data  = $urandom;
        @(negedge clka);
        chk("mid_rst_state", 64'(st1), 64'(IDLE));
        chk("mid_rst_ready", {63'd0, bus1.s_ready}, 64'd0);
        chk("mid_rst_done", {63'd0, done1}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy1}, 64'd0);
        chk("mid_rst_ww", {48'd0, ww1}, 64'd0);
        chk("mid_rst_addra", {32'd0, bus1.addra}, 64'd0);
        chk("mid_rst_dina", {32'd0, bus1.dina}, 64'd0);
        chk("mid_rst_wea", {60'd0, bus1.wea}, 64'd0);
        chk("mid_rst_inflight", {32'd0, ram[54]}, {32'd0, exp_mem[54]});
        rsta    = 1'b0;
        s_valid = 1'b0;
        @(negedge clka);
        cmd(0, 3);
        drive(0, -1, 3, -1);
        expect_done("after_rst", 3, 1'b0);

        repeat (2) @(negedge clka);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_stream_writer.md
# bram_stream_writer

Port-A write sequencer for the dual-port block RAM (`design_2_wrapper`). It accepts a valid/ready word stream and writes a programmed number of words to consecutive RAM locations starting at a base address, driving `addra`/`dina`/`ena`/`wea` directly. Port B reads the stored data back once `done` pulses.

## Interface
- `ADDR_W`, 32: width of `addra` and `base_addr`.
- `DATA_W`, 32: stream and RAM data width; must be a multiple of 8.
- `DEPTH`, 1024: RAM depth in words; power of two.
- `ADDR_STEP`, 1: `addra` increment per word; 1 = word addressing, 4 = byte addressing.
- `clka`  in  1: sole clock.
- `rsta`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle command; sampled only in IDLE.
- `base_addr`  in  ADDR_W: first word index, sampled with `start`.
- `length`  in  16: words to write, sampled with `start`.
- `s_data`  in  DATA_W: stream data.
- `s_valid`  in  1: stream valid.
- `s_last`  in  1: marks the final stream word.
- `s_ready`  out  1: stream ready.
- `addra`  out  ADDR_W: RAM port-A address.
- `dina`  out  DATA_W: RAM port-A write data.
- `ena`  out  1: RAM port-A enable.
- `wea`  out  DATA_W/8: byte write enables.
- `busy`  out  1: high in WRITE and DONE.
- `done`  out  1: one-cycle completion pulse.
- `words_written`  out  16: words committed in the current or last command.
- `err_short`  out  1: sticky; `s_last` arrived before `length` words.

## Operation
- FSM states are IDLE, WRITE and DONE.
- In IDLE, `start` latches `base_addr` into `word_ptr`, latches `length`, and clears `words_written` and `err_short`.
  - If `length` is 0, go to DONE.
  - Otherwise, go to WRITE.
- `start` outside IDLE is ignored.
- `s_ready` = (state == WRITE). It is combinational from the state register only.
- Handshake: `s_valid & s_ready` at a rising edge. Each accepted word:
  - registers `dina <= s_data`, `addra <= word_ptr*ADDR_STEP`, `ena <= 1`, `wea <= all ones`;
  - increments `word_ptr` modulo DEPTH, so DEPTH-1 wraps to 0;
  - increments `words_written`.
- A cycle with no handshake registers `ena = 0` and `wea = 0`. `addra` and `dina` hold their last values.
- Termination occurs on a handshake where `words_written == length-1` or `s_last = 1`, whichever comes first. The FSM then goes to DONE.
  - If termination is caused by `s_last` with `words_written+1 < length`, set `err_short`.
  - If `s_last` coincides with the final word, no error is flagged.
- Stream words beyond `length` are not accepted, because `s_ready` is low.
- DONE lasts exactly one cycle: `done = 1`, then the FSM returns to IDLE.
- Width rules:
  - `word_ptr` is log2(DEPTH) bits.
  - `base_addr` is truncated to log2(DEPTH) bits.
  - `addra` is zero-extended to ADDR_W.

## Timing
- All outputs except `s_ready` are registered.
- Word accepted at edge n: `ena`, `wea`, `addra` and `dina` are valid in cycle n..n+1, and the RAM commits at edge n+1.
- Throughput is one word per cycle while `s_valid` is held.
- First `s_ready` is the cycle after the edge that samples `start`.
- `done` is high in the same cycle as the final write's `ena`. Port-B reads are valid from the following edge.
- For `length` = 0, `done` occurs one cycle after `start` and no `ena` is issued.
- Reset applies at the next edge and overrides everything, including mid-command:
  - state = IDLE;
  - `s_ready`, `ena`, `done`, `busy`, `err_short` = 0;
  - `wea`, `addra`, `dina`, `words_written` = 0.
- A write in flight at the reset edge still commits. No further `ena` follows.

## Structure
- Package `bram_pkg`:
  - state enum `wr_state_t` {IDLE, WRITE, DONE};
  - default width constants;
  - localparam `WE_ALL` = all-ones byte enable.
- Sub-module `bram_addr_gen`:
  - loadable word pointer with modulo-DEPTH increment and ADDR_STEP scaling;
  - ports: `clka`, `rsta`, `load`, `load_val`, `inc`, `addr`.
- The FSM and output registers live in the top module.

## Test plan
- `start`, base 0, length 100, `s_valid` held, `$random` data → `addra` 0..99 on 100 consecutive `ena` cycles, `wea` = 4'hF. `done` with the 100th write, `words_written` = 100. A port-B readback of addresses 0..99 matches the data.
- `s_valid` toggling every other cycle, length 8 → exactly 8 `ena` pulses aligned to handshakes, and no `ena` in gap cycles.
- Wrap: base 1022, length 4, DEPTH 1024 → `addra` 1022, 1023, 0, 1. With ADDR_STEP 4: 4088, 4092, 0, 4.
- Early `s_last` on the 3rd word, length 10 → 3 writes, `done`, `err_short` = 1, `words_written` = 3. The next `start` clears `err_short`.
- Length 0 → `done` one cycle after `start`, `ena` never asserted. A `start` pulse during WRITE is ignored and `length` is unchanged.
- `rsta` asserted after 5 of 20 words → all outputs 0 the cycle after the reset edge, `s_ready` low. A new command after reset completes normally.
